// File: rtl/moving_platform.sv
// Platform that shuttles between a home and a far position one step per divided
// frame tick, reports per-step displacement, sprite hit-testing and rider detection.
module moving_platform #(
   parameter int WIDTH     = 64,
   parameter int HEIGHT    = 16,
   parameter int START_X   = 23,
   parameter int START_Y   = 256,
   parameter int END_X     = 23,
   parameter int END_Y     = 303,
   parameter int SPEED     = 1,
   parameter int FRAME_DIV = 3,
   parameter int MODE      = 0
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               frame_clk,
   input  logic               trigger,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic signed [15:0] p1_left,
   input  logic signed [15:0] p1_right,
   input  logic signed [15:0] p1_bottom,
   input  logic signed [15:0] p2_left,
   input  logic signed [15:0] p2_right,
   input  logic signed [15:0] p2_bottom,
   output logic signed [15:0] pos_x,
   output logic signed [15:0] pos_y,
   output logic               is_platform,
   output logic [15:0]        rom_addr,
   output logic               step_valid,
   output logic signed [15:0] step_dx,
   output logic signed [15:0] step_dy,
   output logic               p1_riding,
   output logic               p2_riding,
   output logic [1:0]         state,
   output logic               busy
);
   typedef enum logic [1:0] {
      AT_START = 2'd0,
      FWD      = 2'd1,
      AT_END   = 2'd2,
      BACK     = 2'd3
   } state_t;

   localparam logic signed [15:0] SX    = 16'(START_X);
   localparam logic signed [15:0] SY    = 16'(START_Y);
   localparam logic signed [15:0] EX    = 16'(END_X);
   localparam logic signed [15:0] EY    = 16'(END_Y);
   localparam logic signed [15:0] W16   = 16'(WIDTH);
   localparam logic signed [15:0] H16   = 16'(HEIGHT);
   localparam logic signed [15:0] SPD16 = 16'(SPEED);
   localparam logic signed [16:0] SPD17 = 17'(SPEED);
   localparam logic [7:0]         DIV   = 8'(FRAME_DIV);

   state_t             state_q, state_d;
   logic               fc_s, fc_prev, frame_tick;
   logic               trig_s, trig_prev, goal;
   logic [7:0]         div_cnt;
   logic               step_now, moving, arrived;
   logic signed [15:0] tgt_x, tgt_y, nx, ny;
   logic signed [15:0] rel_x, rel_y;

   // Move one axis toward its target by at most SPEED, landing exactly on it.
   function automatic logic signed [15:0] approach(input logic signed [15:0] p,
                                                   input logic signed [15:0] t);
      logic signed [16:0] diff;
      diff = {t[15], t} - {p[15], p};
      if (diff <= SPD17 && diff >= -SPD17)
         approach = t;
      else if (diff > 17'sd0)
         approach = p + SPD16;
      else
         approach = p - SPD16;
   endfunction

   // Previous samples reset high so levels held through reset produce no edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fc_s       <= 1'b1;
         fc_prev    <= 1'b1;
         frame_tick <= 1'b0;
         trig_s     <= 1'b1;
         trig_prev  <= 1'b1;
      end else begin
         fc_s       <= frame_clk;
         fc_prev    <= fc_s;
         frame_tick <= fc_s & ~fc_prev;
         trig_s     <= trigger;
         trig_prev  <= trig_s;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         div_cnt <= 8'd0;
      else if (frame_tick)
         div_cnt <= (div_cnt == DIV) ? 8'd0 : div_cnt + 8'd1;
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         goal <= 1'b0;
      else if (MODE == 0)
         goal <= trigger;
      else if (trig_s && !trig_prev)
         goal <= ~goal;
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         state_q <= AT_START;
      else
         state_q <= state_d;
   end

   // Target follows the current direction, so a goal flip on a step cycle
   // still completes that step toward the old target.
   always_comb begin
      step_now = frame_tick && (div_cnt == DIV);
      moving   = step_now && (state_q == FWD || state_q == BACK);
      tgt_x    = (state_q == BACK) ? SX : EX;
      tgt_y    = (state_q == BACK) ? SY : EY;
      nx       = approach(pos_x, tgt_x);
      ny       = approach(pos_y, tgt_y);
      arrived  = moving && (nx == tgt_x) && (ny == tgt_y);
      state_d  = state_q;
      case (state_q)
         AT_START: if (goal) state_d = FWD;
         AT_END:   if (!goal) state_d = BACK;
         FWD: begin
            if (arrived)    state_d = AT_END;
            else if (!goal) state_d = BACK;
         end
         BACK: begin
            if (arrived)   state_d = AT_START;
            else if (goal) state_d = FWD;
         end
         default: state_d = AT_START;
      endcase
   end

   always_comb begin
      busy        = (state_q == FWD) || (state_q == BACK);
      rel_x       = $signed({6'd0, DrawX}) - pos_x;
      rel_y       = $signed({6'd0, DrawY}) - pos_y;
      is_platform = (rel_x >= 16'sd0) && (rel_x < W16) &&
                    (rel_y >= 16'sd0) && (rel_y < H16);
      rom_addr    = 16'(rel_y * W16 + rel_x);
   end

   assign state = state_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pos_x      <= SX;
         pos_y      <= SY;
         step_valid <= 1'b0;
         step_dx    <= 16'sd0;
         step_dy    <= 16'sd0;
      end else if (moving) begin
         pos_x      <= nx;
         pos_y      <= ny;
         step_valid <= (nx != pos_x) || (ny != pos_y);
         step_dx    <= nx - pos_x;
         step_dy    <= ny - pos_y;
      end else begin
         step_valid <= 1'b0;
         step_dx    <= 16'sd0;
         step_dy    <= 16'sd0;
      end
   end

   // A player rides when standing on the row just above the top edge and overlapping it.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         p1_riding <= 1'b0;
         p2_riding <= 1'b0;
      end else begin
         p1_riding <= (p1_bottom == pos_y - 16'sd1) && (p1_right >= pos_x) &&
                      (p1_left <= pos_x + W16 - 16'sd1);
         p2_riding <= (p2_bottom == pos_y - 16'sd1) && (p2_right >= pos_x) &&
                      (p2_left <= pos_x + W16 - 16'sd1);
      end
   end
endmodule

// File: tb/tb_moving_platform.sv
// Bench for moving_platform: default, SPEED=4 and toggle-mode instances, a step
// scoreboard fed by a behavioural model, and table vectors for hit-test/riding.
module tb_moving_platform;
   logic Clk = 1'b0;
   logic Reset, frame_clk, trig0, trig1, trig2;
   logic [9:0] DrawX, DrawY;
   logic signed [15:0] p1_left, p1_right, p1_bottom, p2_left, p2_right, p2_bottom;

   logic signed [15:0] u0_pos_x, u0_pos_y, u0_step_dx, u0_step_dy;
   logic u0_is_platform, u0_step_valid, u0_p1_riding, u0_p2_riding, u0_busy;
   logic [15:0] u0_rom_addr;
   logic [1:0] u0_state;

   logic signed [15:0] u1_pos_x, u1_pos_y, u1_step_dx, u1_step_dy;
   logic u1_is_platform, u1_step_valid, u1_p1_riding, u1_p2_riding, u1_busy;
   logic [15:0] u1_rom_addr;
   logic [1:0] u1_state;

   logic signed [15:0] u2_pos_x, u2_pos_y, u2_step_dx, u2_step_dy;
   logic u2_is_platform, u2_step_valid, u2_p1_riding, u2_p2_riding, u2_busy;
   logic [15:0] u2_rom_addr;
   logic [1:0] u2_state;

   always #5 Clk = ~Clk;

   moving_platform u0 (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .trigger(trig0),
      .DrawX(DrawX), .DrawY(DrawY),
      .p1_left(p1_left), .p1_right(p1_right), .p1_bottom(p1_bottom),
      .p2_left(p2_left), .p2_right(p2_right), .p2_bottom(p2_bottom),
      .pos_x(u0_pos_x), .pos_y(u0_pos_y), .is_platform(u0_is_platform),
      .rom_addr(u0_rom_addr), .step_valid(u0_step_valid),
      .step_dx(u0_step_dx), .step_dy(u0_step_dy),
      .p1_riding(u0_p1_riding), .p2_riding(u0_p2_riding),
      .state(u0_state), .busy(u0_busy));

   moving_platform #(.SPEED(4)) u1 (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .trigger(trig1),
      .DrawX(DrawX), .DrawY(DrawY),
      .p1_left(p1_left), .p1_right(p1_right), .p1_bottom(p1_bottom),
      .p2_left(p2_left), .p2_right(p2_right), .p2_bottom(p2_bottom),
      .pos_x(u1_pos_x), .pos_y(u1_pos_y), .is_platform(u1_is_platform),
      .rom_addr(u1_rom_addr), .step_valid(u1_step_valid),
      .step_dx(u1_step_dx), .step_dy(u1_step_dy),
      .p1_riding(u1_p1_riding), .p2_riding(u1_p2_riding),
      .state(u1_state), .busy(u1_busy));

   moving_platform #(.MODE(1)) u2 (
      .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .trigger(trig2),
      .DrawX(DrawX), .DrawY(DrawY),
      .p1_left(p1_left), .p1_right(p1_right), .p1_bottom(p1_bottom),
      .p2_left(p2_left), .p2_right(p2_right), .p2_bottom(p2_bottom),
      .pos_x(u2_pos_x), .pos_y(u2_pos_y), .is_platform(u2_is_platform),
      .rom_addr(u2_rom_addr), .step_valid(u2_step_valid),
      .step_dx(u2_step_dx), .step_dy(u2_step_dy),
      .p1_riding(u2_p1_riding), .p2_riding(u2_p2_riding),
      .state(u2_state), .busy(u2_busy));

   typedef struct { int x; int y; int is_p; int addr; } pix_vec_t;
   typedef struct { int l1; int r1; int b1; int l2; int r2; int b2; int e1; int e2; } ride_vec_t;
   pix_vec_t  pix_tab [9];
   ride_vec_t ride_tab [4];

   // {pos_y, step_dy} of each expected step
   logic [31:0] exp_q[$];
   logic [31:0] exp1_q[$];
   int errors = 0;
   int checks = 0;

   // behavioural model of u0 (SPEED 1, FRAME_DIV 3, MODE 0)
   int m_cnt, m_state, m_y, m_goal;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cycle();
      logic [31:0] e;
      @(negedge Clk);
      if (!Reset && u0_step_valid) begin
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL u0_unexpected_step: got step to y=%0d, expected none", u0_pos_y);
         end else begin
            e = exp_q.pop_front();
            check("u0_step_pos_y", u0_pos_y, $signed(e[31:16]));
            check("u0_step_dy", u0_step_dy, $signed(e[15:0]));
            check("u0_step_dx", u0_step_dx, 0);
         end
      end
      if (!Reset && u1_step_valid) begin
         if (exp1_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL u1_unexpected_step: got step to y=%0d, expected none", u1_pos_y);
         end else begin
            e = exp1_q.pop_front();
            check("u1_step_pos_y", u1_pos_y, $signed(e[31:16]));
            check("u1_step_dy", u1_step_dy, $signed(e[15:0]));
         end
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_state = 0; m_y = 256; m_goal = 0;
   endtask

   task automatic pulse();
      int tgt, d, ny;
      if (m_cnt == 3) begin
         m_cnt = 0;
         if (m_state == 1 || m_state == 3) begin
            tgt = (m_state == 1) ? 303 : 256;
            d = tgt - m_y;
            if (d <= 1 && d >= -1) ny = tgt;
            else ny = m_y + ((d > 0) ? 1 : -1);
            if (ny != m_y) exp_q.push_back({16'(ny), 16'(ny - m_y)});
            m_y = ny;
            if (m_y == tgt) m_state = (m_state == 1) ? 2 : 0;
         end
      end else begin
         m_cnt++;
      end
      frame_clk = 1'b1;
      repeat (3) cycle();
      frame_clk = 1'b0;
      repeat (3) cycle();
   endtask

   task automatic pulse_chk();
      pulse();
      check("u0_pos_y", u0_pos_y, m_y);
      check("u0_state", u0_state, m_state);
   endtask

   task automatic set_trig0(input logic v);
      trig0 = v;
      m_goal = v;
      if (m_state == 0 && v) m_state = 1;
      else if (m_state == 2 && !v) m_state = 3;
      else if (m_state == 1 && !v) m_state = 3;
      else if (m_state == 3 && v) m_state = 1;
      repeat (3) cycle();
   endtask

   task automatic run_until(input int ty, input int ts, input string name);
      int n;
      n = 0;
      while (!(m_y == ty && m_state == ts) && n < 200) begin
         pulse_chk();
         n++;
      end
      check({name, "_pos_y"}, u0_pos_y, ty);
      check({name, "_state"}, u0_state, ts);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      pix_tab[0] = '{23, 256, 1, 0};
      pix_tab[1] = '{86, 256, 1, 63};
      pix_tab[2] = '{87, 256, 0, 0};
      pix_tab[3] = '{22, 256, 0, 0};
      pix_tab[4] = '{23, 271, 1, 960};
      pix_tab[5] = '{86, 271, 1, 1023};
      pix_tab[6] = '{23, 272, 0, 0};
      pix_tab[7] = '{23, 255, 0, 0};
      pix_tab[8] = '{50, 260, 1, 283};
      ride_tab[0] = '{80, 100, 255, 80, 100, 256, 1, 0};
      ride_tab[1] = '{87, 100, 255, 0, 22, 255, 0, 0};
      ride_tab[2] = '{86, 100, 255, 0, 23, 255, 1, 1};
      ride_tab[3] = '{0, 10, 255, 10, 30, 254, 0, 0};

      Reset = 1'b1; frame_clk = 1'b0;
      trig0 = 1'b0; trig1 = 1'b0; trig2 = 1'b0;
      DrawX = '0; DrawY = '0;
      p1_left = '0; p1_right = '0; p1_bottom = '0;
      p2_left = '0; p2_right = '0; p2_bottom = '0;
      model_reset();
      repeat (3) cycle();
      check("rst_pos_x", u0_pos_x, 23);
      check("rst_pos_y", u0_pos_y, 256);
      check("rst_state", u0_state, 0);
      check("rst_busy", u0_busy, 0);
      check("rst_step_valid", u0_step_valid, 0);
      check("rst_step_dy", u0_step_dy, 0);
      check("rst_p1_riding", u0_p1_riding, 0);
      Reset = 1'b0;
      cycle();

      for (int i = 0; i < 9; i++) begin
         DrawX = 10'(pix_tab[i].x);
         DrawY = 10'(pix_tab[i].y);
         #1;
         check($sformatf("is_platform_%0d", i), u0_is_platform, pix_tab[i].is_p);
         if (pix_tab[i].is_p == 1)
            check($sformatf("rom_addr_%0d", i), u0_rom_addr, pix_tab[i].addr);
         cycle();
      end

      for (int i = 0; i < 4; i++) begin
         p1_left = 16'(ride_tab[i].l1); p1_right = 16'(ride_tab[i].r1);
         p1_bottom = 16'(ride_tab[i].b1);
         p2_left = 16'(ride_tab[i].l2); p2_right = 16'(ride_tab[i].r2);
         p2_bottom = 16'(ride_tab[i].b2);
         repeat (2) cycle();
         check($sformatf("p1_riding_%0d", i), u0_p1_riding, ride_tab[i].e1);
         check($sformatf("p2_riding_%0d", i), u0_p2_riding, ride_tab[i].e2);
      end

      // full forward run from home
      set_trig0(1'b1);
      check("fwd_state", u0_state, 1);
      check("fwd_busy", u0_busy, 1);
      repeat (4) pulse_chk();
      check("first_step_y", u0_pos_y, 257);
      run_until(303, 2, "at_end");
      check("at_end_busy", u0_busy, 0);
      repeat (8) pulse_chk();

      // return, then reverse mid-move at 280
      set_trig0(1'b0);
      check("back_state", u0_state, 3);
      run_until(256, 0, "home1");
      set_trig0(1'b1);
      run_until(280, 1, "reach280");
      set_trig0(1'b0);
      check("rev_state", u0_state, 3);
      run_until(279, 3, "rev_step");
      run_until(256, 0, "home2");

      // SPEED 4 instance
      trig1 = 1'b1;
      for (int k = 1; k <= 11; k++) exp1_q.push_back({16'(256 + 4 * k), 16'(4)});
      exp1_q.push_back({16'(303), 16'(3)});
      repeat (3) cycle();
      n = 0;
      while (exp1_q.size() > 0 && n < 100) begin
         pulse_chk();
         n++;
      end
      check("u1_steps_left", exp1_q.size(), 0);
      check("u1_pos_y", u1_pos_y, 303);
      check("u1_state", u1_state, 2);

      // toggle-mode instance
      trig2 = 1'b1;
      repeat (4) cycle();
      check("u2_toggle_fwd", u2_state, 1);
      trig2 = 1'b0;
      repeat (8) pulse_chk();
      check("u2_pos_y_mid", u2_pos_y, 258);
      trig2 = 1'b1;
      repeat (4) cycle();
      check("u2_toggle_back", u2_state, 3);
      repeat (10) cycle();
      check("u2_held_high", u2_state, 3);
      trig2 = 1'b0;
      repeat (8) pulse_chk();
      check("u2_home_y", u2_pos_y, 256);
      check("u2_home_state", u2_state, 0);

      // reset mid-move with frame_clk and trigger held high
      set_trig0(1'b1);
      run_until(290, 1, "pre_reset");
      trig1 = 1'b0;
      frame_clk = 1'b1;
      Reset = 1'b1;
      cycle();
      check("mid_rst_pos_y", u0_pos_y, 256);
      check("mid_rst_state", u0_state, 0);
      check("mid_rst_step_valid", u0_step_valid, 0);
      cycle();
      Reset = 1'b0;
      model_reset();
      m_goal = 1;
      m_state = 1;
      repeat (3) cycle();
      check("post_rst_state", u0_state, 1);
      frame_clk = 1'b0;
      cycle();
      repeat (4) pulse_chk();
      check("post_rst_first_step", u0_pos_y, 257);

      check("u0_steps_left", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/moving_platform.md
MOVING_PLATFORM -- requirements
Module: moving_platform

Interface
REQ-001 SHALL have parameter WIDTH, 64, platform width in pixels.
REQ-002 SHALL have parameter HEIGHT, 16, platform height in pixels.
REQ-003 SHALL have parameters START_X, START_Y, 23, 256, home position (top-left).
REQ-004 SHALL have parameters END_X, END_Y, 23, 303, far position (top-left).
REQ-005 SHALL have parameter SPEED, 1, max pixels moved per axis per step (>=1).
REQ-006 SHALL have parameter FRAME_DIV, 3, one step per FRAME_DIV+1 frame ticks (0..255).
REQ-007 SHALL have parameter MODE, 0, 0=level (trigger held selects END), 1=toggle (trigger rising edge flips goal).
REQ-008 SHALL have ports: Clk in 1, system clock; Reset in 1, reset.
REQ-009 SHALL have: frame_clk in 1 vsync-rate strobe; trigger in 1 switch/lever.
REQ-010 SHALL have: DrawX, DrawY in 10 each, current pixel.
REQ-011 SHALL have: p1_left, p1_right, p1_bottom, p2_left, p2_right, p2_bottom in 16 signed each, player bounds.
REQ-012 SHALL have: pos_x, pos_y out 16 signed, platform top-left; is_platform out 1; rom_addr out 16, (DrawY-pos_y)*WIDTH+(DrawX-pos_x).
REQ-013 SHALL have: step_valid out 1; step_dx, step_dy out 16 signed, displacement of the step.
REQ-014 SHALL have: p1_riding, p2_riding out 1; state out 2; busy out 1.
REQ-015 Reset is Reset, synchronous, active-high; clock is Clk.

Function
REQ-016 frame_clk SHALL be registered and edge-detected; frame_tick high exactly one Clk cycle per 0->1 transition, 2 cycles after the transition is sampled.
REQ-017 Divider counter SHALL increment on frame_tick, wrap FRAME_DIV->0; a step occurs on the frame_tick where counter==FRAME_DIV.
REQ-018 goal bit: MODE 0 goal=trigger sampled each cycle; MODE 1 goal toggles on each registered 0->1 of trigger; target=(goal?END:START).
REQ-019 States: AT_START=0, FWD=1, AT_END=2, BACK=3; AT_START->FWD when goal=1; AT_END->BACK when goal=0; FWD->BACK when goal=0; BACK->FWD when goal=1; the state change takes effect in the cycle after goal changes, no step needed.
REQ-020 On a step in FWD/BACK, per axis: if |target-pos|<=SPEED pos=target, else pos+=sign(target-pos)*SPEED; no overshoot, diagonal paths allowed.
REQ-021 When both axes equal target after a step, state SHALL become AT_END (FWD) or AT_START (BACK) in the same update.
REQ-022 No movement in AT_START/AT_END; divider keeps running regardless of state.
REQ-023 step_valid SHALL pulse one cycle, registered with the position update, only if pos changed; step_dx/dy = applied delta then, else 0.
REQ-024 busy = state is FWD or BACK.
REQ-025 is_platform SHALL be combinational: 0<=DrawX-pos_x<WIDTH and 0<=DrawY-pos_y<HEIGHT, signed 16-bit compare; rom_addr don't-care when 0.
REQ-026 pN_riding SHALL be registered each cycle: pN_bottom==pos_y-1 and pN_right>=pos_x and pN_left<=pos_x+WIDTH-1.
REQ-027 Goal reversal on the same cycle as a step: step SHALL use the pre-reversal target; new direction applies from the next step.

Reset
REQ-028 Reset SHALL set pos=(START_X,START_Y), state AT_START, goal 0, counter 0, step_valid 0, step_dx/dy 0, riding 0.
REQ-029 Reset SHALL set frame_clk and trigger previous samples to 1 so levels held high through reset cause no edge; reset mid-move discards progress.

Verification
REQ-030 Defaults, MODE 0, trigger=1 held -> first step after 4 frame ticks, pos_y 257, step_dy=+1; 47th step pos_y=303, state AT_END, busy 0; ticks thereafter give no step_valid.
REQ-031 SPEED=4, trigger=1 -> pos_y 260..300 in 11 steps; 12th step pos_y=303, step_dy=+3, AT_END.
REQ-032 MODE 0, trigger dropped at pos_y=280 -> state BACK; next step pos_y=279, step_dy=-1; reaches 256 then AT_START.
REQ-033 MODE 1, trigger pulse 1-0 -> FWD; second pulse mid-move -> BACK; trigger held high with no edge -> no change.
REQ-034 pos=(23,256), p1_bottom=255, p1_left=80, p1_right=100 -> p1_riding=1; p1_left=87 -> 0; p2_bottom=256 -> p2_riding=0.
REQ-035 Reset asserted at pos_y=290 with frame_clk and trigger high -> next cycle pos_y=256, AT_START, step_valid 0, no tick on release.
